dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: NUM_WORDS, 8, number of 32-bit words in the shared data memory; legal addresses are 0 to 4*NUM_WORDS-1.
REQ-002 Port: clk  input  1  single rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: mN_req  input  1  request from requester N (N=0 core LSU, N=1 debug loader).
REQ-005 Port: mN_addr  input  32  byte address.
REQ-006 Port: mN_wdata  input  32  store data, right-aligned.
REQ-007 Port: mN_is_load  input  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU.
REQ-008 Port: mN_is_store  input  2  store code: 00 none, 01 SB, 10 SH, 11 SW.
REQ-009 Port: mN_lock  input  1  keep ownership after this transaction; used only with the lock feature.
REQ-010 Port: mN_gnt  output  1  request accepted this cycle.
REQ-011 Port: mN_rvalid  output  1  response valid, exactly one per grant.
REQ-012 Port: mN_rdata  output  32  registered load data; 0 for stores and errors.
REQ-013 Port: mN_err  output  1  response is an error, qualified by mN_rvalid.
REQ-014 Port: mem_addr, mem_wdata  output  32  memory address and store data.
REQ-015 Port: mem_is_load  output  3  memory load code.
REQ-016 Port: mem_is_store  output  2  memory store code.
REQ-017 Port: mem_rdata  input  32  combinational memory read data.

Function
REQ-018 A requester SHALL hold req, addr, wdata and the codes stable until it sees gnt.
- At most one gnt per cycle.
- gnt is combinational from req and arbiter state.
REQ-019 In the grant cycle the granted request SHALL drive the mem_* outputs.
- The memory write commits at that clock edge.
- With no grant, mem_is_load=000 and mem_is_store=00.
REQ-020 The response SHALL arrive one cycle after gnt.
- rvalid=1 for exactly one cycle.
- rdata holds mem_rdata registered at the grant edge.
- Back-to-back grants give one transaction per cycle.
REQ-021 Arbitration SHALL be round-robin with a last-granted pointer.
- When both request, the requester not granted last wins.
- The pointer resets to favour m0.
REQ-022 The following requests SHALL be flagged as errors:
- both load and store codes non-zero;
- load code 100 or 111;
- halfword access with addr[1:0]=11;
- word access with addr[1:0]!=00;
- addr >= 4*NUM_WORDS.
REQ-023 An error request SHALL still be granted, with mem codes forced to none and no memory update.
- The next cycle gives rvalid=1, err=1, rdata=0.
REQ-024 A request with both codes none SHALL be granted as a no-op and answered with rvalid=1, err=0, rdata=0.
REQ-025 State machine states: IDLE, OWN0, OWN1.
- IDLE: round-robin arbitration.
- OWNn: only requester n can be granted; the other requester waits.
- Enter OWNn on a grant to n with mN_lock=1.
- Return to IDLE on a grant to n with mN_lock=0.

Reset
REQ-026 While rst_n=0: state=IDLE, pointer favours m0, and all gnt, rvalid, err, rdata and mem_* outputs are 0.
REQ-027 A reset asserted mid-transaction SHALL drop any pending response with no rvalid after reset release.

Configuration
REQ-028 With DMEM_ARB_LOCK_EN defined, the lock behaviour of REQ-025 applies.
REQ-029 Without DMEM_ARB_LOCK_EN, mN_lock is ignored, the FSM stays in IDLE, and arbitration is pure round-robin.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold:
- the load and store code constants;
- the state enum;
- the response struct {rvalid, err, rdata}.
REQ-031 The two-way round-robin picker SHALL be a sub-module rr_arb2 with inputs req[1:0] and ptr, and output a one-hot gnt.

Verification
REQ-032 m0 SW 0xDEADBEEF to addr 0x4, then LW at 0x4 -> m0_rvalid one cycle after the second gnt, m0_rdata=0xDEADBEEF, err=0.
REQ-033 m0 and m1 both hold loads for 4 cycles -> grants go m0, m1, m0, m1.
REQ-034 m1 LH at addr 0x3 -> m1_gnt, mem_is_load=000, next cycle m1_err=1, rdata=0, memory unchanged.
REQ-035 Word 0 holds 0x000080FF; LB at 0x0 -> 0xFFFFFFFF; LBU at 0x0 -> 0x000000FF; LHU at 0x0 -> 0x000080FF.
REQ-036 With DMEM_ARB_LOCK_EN, m0 LW lock=1 then SW lock=0 while m1 requests throughout -> m1 is not granted until the cycle after the m0 store grant.
REQ-037 Assert rst_n low in the cycle after a gnt -> no rvalid appears, and after release all outputs are 0 until the next request.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the two-port data-memory arbiter.
//   - load / store code constants as seen on mN_is_load / mN_is_store
//   - arbiter FSM state enum
//   - per-requester response record {rvalid, err, rdata}
//   - access_err(): classifies a request as malformed / out of range
package dmem_arb_pkg;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b101;
    localparam logic [2:0] LD_LHU  = 3'b110;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // A pure no-op (both codes none) is never an error, whatever its address.
    function automatic logic access_err(input logic [31:0] addr,
                                        input logic [2:0]  ld,
                                        input logic [1:0]  st,
                                        input logic [31:0] limit);
        logic is_half;
        logic is_word;
        logic is_acc;
        is_half    = (ld == LD_LH) || (ld == LD_LHU) || (st == ST_SH);
        is_word    = (ld == LD_LW) || (st == ST_SW);
        is_acc     = (ld != LD_NONE) || (st != ST_NONE);
        access_err = 1'b0;
        if ((ld != LD_NONE) && (st != ST_NONE)) access_err = 1'b1;
        if ((ld == 3'b100) || (ld == 3'b111))    access_err = 1'b1;
        if (is_half && (addr[1:0] == 2'b11))     access_err = 1'b1;
        if (is_word && (addr[1:0] != 2'b00))     access_err = 1'b1;
        if (is_acc && (addr >= limit))           access_err = 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker.
//   req[1:0] : request vector
//   ptr      : index of the requester granted last
//   gnt[1:0] : one-hot grant (all zero when nothing requests)
// On contention the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = ptr ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core LSU (m0) and the
// debug loader (m1).
//   clk, rst_n          : clock, async active-low reset
//   mN_req/addr/wdata   : request, byte address, right-aligned store data
//   mN_is_load/is_store : access codes (see dmem_arb_pkg)
//   mN_lock             : keep ownership after this transaction
//   mN_gnt              : request accepted this cycle (combinational)
//   mN_rvalid/err/rdata : registered response, one cycle after gnt
//   mem_*               : memory port, driven by the granted request
//   mem_rdata           : combinational (already extended) memory read data
// Build option: DMEM_ARB_LOCK_EN enables the OWN0/OWN1 lock states; without
// it mN_lock is ignored and arbitration is pure round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_is_load,
    input  logic [1:0]  m0_is_store,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_is_load,
    input  logic [1:0]  m1_is_store,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_is_load,
    output logic [1:0]  mem_is_store,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIM = 32'(4 * NUM_WORDS);

    logic [1:0]       req_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0][2:0]  ld_v;
    logic [1:0][1:0]  st_v;
    logic [1:0]       lock_v;

    assign req_v   = {m1_req, m0_req};
    assign addr_v  = {m1_addr, m0_addr};
    assign wdata_v = {m1_wdata, m0_wdata};
    assign ld_v    = {m1_is_load, m0_is_load};
    assign st_v    = {m1_is_store, m0_is_store};
    assign lock_v  = {m1_lock, m0_lock};

    arb_state_e state_q, state_d;
    logic       last_q;     // index of last granted requester
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel;
    logic       sel_err;
    resp_t [1:0] resp_q;

    rr_arb2 u_rr (
        .req (req_v),
        .ptr (last_q),
        .gnt (rr_gnt)
    );

    // Grant is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (state_q)
                OWN0:    gnt = {1'b0, req_v[0]};
                OWN1:    gnt = {req_v[1], 1'b0};
                default: gnt = rr_gnt;
            endcase
        end
    end

    assign any_gnt = |gnt;
    assign sel     = gnt[1];
    assign sel_err = access_err(addr_v[sel], ld_v[sel], st_v[sel], ADDR_LIM);

    // An erroring grant still shows its address but never touches memory.
    assign mem_addr     = any_gnt ? addr_v[sel]  : 32'h0;
    assign mem_wdata    = any_gnt ? wdata_v[sel] : 32'h0;
    assign mem_is_load  = (any_gnt && !sel_err) ? ld_v[sel] : LD_NONE;
    assign mem_is_store = (any_gnt && !sel_err) ? st_v[sel] : ST_NONE;

    always_comb begin
        state_d = state_q;
`ifdef DMEM_ARB_LOCK_EN
        if (any_gnt) begin
            if (lock_v[sel]) state_d = sel ? OWN1 : OWN0;
            else             state_d = IDLE;
        end
`endif
    end

`ifndef DMEM_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock_v;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // "m1 last" so m0 wins the first contention
        end else begin
            state_q <= state_d;
            if (any_gnt) last_q <= sel;
        end
    end

    // Responses: async reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                resp_q[i].rvalid <= gnt[i];
                resp_q[i].err    <= gnt[i] & sel_err;
                resp_q[i].rdata  <= (gnt[i] && !sel_err && (ld_v[i] != LD_NONE))
                                    ? mem_rdata : 32'h0;
            end
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = resp_q[0].rvalid;
    assign m0_err    = resp_q[0].err;
    assign m0_rdata  = resp_q[0].rdata;
    assign m1_rvalid = resp_q[1].rvalid;
    assign m1_err    = resp_q[1].err;
    assign m1_rdata  = resp_q[1].rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter with a small
// byte-addressed memory model behind the mem_* port.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_is_load, m1_is_load;
    logic [1:0]  m0_is_store, m1_is_store;
    logic        m0_lock, m1_lock;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_is_load;
    logic [1:0]  mem_is_store;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.NUM_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_is_load(m0_is_load), .m0_is_store(m0_is_store), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_is_load(m1_is_load), .m1_is_store(m1_is_store), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .mem_is_store(mem_is_store), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 8 words, extension done on the read side.
    logic [31:0] mem [8];
    logic [31:0] mword;
    logic [15:0] msh;
    logic        unused_hi;
    assign unused_hi = ^mem_addr[31:5];

    always_comb begin
        mem_rdata = 32'h0;
        mword     = mem[mem_addr[4:2]];
        msh       = 16'(mword >> {mem_addr[1:0], 3'b000});
        case (mem_is_load)
            3'b001:  mem_rdata = {{24{msh[7]}}, msh[7:0]};
            3'b010:  mem_rdata = {{16{msh[15]}}, msh[15:0]};
            3'b011:  mem_rdata = mword;
            3'b101:  mem_rdata = {24'h0, msh[7:0]};
            3'b110:  mem_rdata = {16'h0, msh[15:0]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        case (mem_is_store)
            2'b01: mem[mem_addr[4:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
            2'b10: mem[mem_addr[4:2]][{mem_addr[1:0], 3'b000} +: 16] <= mem_wdata[15:0];
            2'b11: mem[mem_addr[4:2]] <= mem_wdata;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        r0;
        logic [31:0] a0, d0;
        logic [2:0]  l0;
        logic [1:0]  s0;
        logic        r1;
        logic [31:0] a1, d1;
        logic [2:0]  l1;
        logic [1:0]  s1;
        logic [1:0]  gnt;
        logic [31:0] maddr;
        logic [2:0]  mld;
        logic [1:0]  mst;
        logic [1:0]  rv;
        logic [1:0]  er;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vt[$];

    // Single-requester vector on port p.
    function automatic vec_t one(input int p, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] l, input logic [1:0] s,
                                 input logic [2:0] mld, input logic [1:0] mst,
                                 input logic e, input logic [31:0] rd);
        vec_t v;
        v = '{default: '0};
        if (p == 0) begin
            v.r0 = 1'b1; v.a0 = a; v.d0 = d; v.l0 = l; v.s0 = s;
            v.gnt = 2'b01; v.rv = 2'b01; v.er = {1'b0, e}; v.rd0 = rd;
        end else begin
            v.r1 = 1'b1; v.a1 = a; v.d1 = d; v.l1 = l; v.s1 = s;
            v.gnt = 2'b10; v.rv = 2'b10; v.er = {e, 1'b0}; v.rd1 = rd;
        end
        v.maddr = a; v.mld = mld; v.mst = mst;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m0_req = v.r0; m0_addr = v.a0; m0_wdata = v.d0; m0_is_load = v.l0; m0_is_store = v.s0;
        m1_req = v.r1; m1_addr = v.a1; m1_wdata = v.d1; m1_is_load = v.l1; m1_is_store = v.s1;
        m0_lock = 1'b0; m1_lock = 1'b0;
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        // ---- reset state, with a request pending ----
        idle_inputs();
        rst_n = 1'b0;
        m0_req = 1'b1; m0_is_load = 3'b011;
        #2;
        chk("rst gnt",    {30'h0, m1_gnt, m0_gnt}, 32'h0);
        chk("rst memld",  {29'h0, mem_is_load}, 32'h0);
        chk("rst maddr",  mem_addr, 32'h0);
        @(posedge clk); #1;
        chk("rst rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rst rdata",  m0_rdata | m1_rdata, 32'h0);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- vector table ----
        vt.push_back(one(0, 32'h4, 32'hDEADBEEF, 3'b000, 2'b11, 3'b000, 2'b11, 1'b0, 32'h0));
        vt.push_back(one(0, 32'h4, 32'h0,        3'b011, 2'b00, 3'b011, 2'b00, 1'b0, 32'hDEADBEEF));
        vt.push_back(one(0, 32'h0, 32'h000080FF, 3'b000, 2'b11, 3'b000, 2'b11, 1'b0, 32'h0));
        vt.push_back(one(0, 32'h0, 32'h0,        3'b001, 2'b00, 3'b001, 2'b00, 1'b0, 32'hFFFFFFFF));
        vt.push_back(one(0, 32'h0, 32'h0,        3'b101, 2'b00, 3'b101, 2'b00, 1'b0, 32'h000000FF));
        vt.push_back(one(0, 32'h0, 32'h0,        3'b110, 2'b00, 3'b110, 2'b00, 1'b0, 32'h000080FF));
        vt.push_back(one(0, 32'h0, 32'h0,        3'b010, 2'b00, 3'b010, 2'b00, 1'b0, 32'hFFFF80FF));
        vt.push_back(one(1, 32'h3, 32'h0,        3'b010, 2'b00, 3'b000, 2'b00, 1'b1, 32'h0));
        vt.push_back(one(1, 32'h0, 32'h0,        3'b011, 2'b00, 3'b011, 2'b00, 1'b0, 32'h000080FF));
        vt.push_back(one(1, 32'h2, 32'h11111111, 3'b000, 2'b11, 3'b000, 2'b00, 1'b1, 32'h0));
        vt.push_back(one(1, 32'h0, 32'h0,        3'b011, 2'b00, 3'b011, 2'b00, 1'b0, 32'h000080FF));
        vt.push_back(one(0, 32'h20, 32'h0,       3'b011, 2'b00, 3'b000, 2'b00, 1'b1, 32'h0));
        vt.push_back(one(1, 32'h0, 32'h0,        3'b100, 2'b00, 3'b000, 2'b00, 1'b1, 32'h0));
        vt.push_back(one(0, 32'h0, 32'h5,        3'b011, 2'b11, 3'b000, 2'b00, 1'b1, 32'h0));
        vt.push_back(one(1, 32'h8, 32'h0,        3'b000, 2'b00, 3'b000, 2'b00, 1'b0, 32'h0));
        vt.push_back(one(1, 32'h1, 32'h000000AA, 3'b000, 2'b01, 3'b000, 2'b01, 1'b0, 32'h0));
        vt.push_back(one(0, 32'h0, 32'h0,        3'b110, 2'b00, 3'b110, 2'b00, 1'b0, 32'h0000AAFF));
        vt.push_back(one(1, 32'h6, 32'h00001234, 3'b000, 2'b10, 3'b000, 2'b10, 1'b0, 32'h0));
        vt.push_back(one(0, 32'h4, 32'h0,        3'b011, 2'b00, 3'b011, 2'b00, 1'b0, 32'h1234BEEF));
        v = '{default: '0};
        vt.push_back(v);                                   // nothing requested
        // contention after an m0 grant: m1 wins
        v = '{default: '0};
        v.r0 = 1'b1; v.a0 = 32'h0; v.l0 = 3'b011;
        v.r1 = 1'b1; v.a1 = 32'h4; v.l1 = 3'b011;
        v.gnt = 2'b10; v.maddr = 32'h4; v.mld = 3'b011; v.rv = 2'b10; v.rd1 = 32'h1234BEEF;
        vt.push_back(v);

        foreach (vt[k]) begin
            drive(vt[k]);
            #1;
            chk($sformatf("v%0d gnt", k),   {30'h0, m1_gnt, m0_gnt}, {30'h0, vt[k].gnt});
            chk($sformatf("v%0d maddr", k), mem_addr, vt[k].maddr);
            chk($sformatf("v%0d memld", k), {29'h0, mem_is_load}, {29'h0, vt[k].mld});
            chk($sformatf("v%0d memst", k), {30'h0, mem_is_store}, {30'h0, vt[k].mst});
            @(posedge clk); #1;
            chk($sformatf("v%0d rvalid", k), {30'h0, m1_rvalid, m0_rvalid}, {30'h0, vt[k].rv});
            chk($sformatf("v%0d err", k),    {30'h0, m1_err, m0_err}, {30'h0, vt[k].er});
            chk($sformatf("v%0d rdata0", k), m0_rdata, vt[k].rd0);
            chk($sformatf("v%0d rdata1", k), m1_rdata, vt[k].rd1);
        end

        // ---- round-robin from reset: both hold loads for 4 cycles ----
        reset_pulse();
        m0_req = 1'b1; m0_addr = 32'h0; m0_is_load = 3'b011;
        m1_req = 1'b1; m1_addr = 32'h4; m1_is_load = 3'b011;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rr%0d gnt", c), {30'h0, m1_gnt, m0_gnt},
                (c % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk); #1;
            chk($sformatf("rr%0d rvalid", c), {30'h0, m1_rvalid, m0_rvalid},
                (c % 2 == 0) ? 32'h1 : 32'h2);
        end

        // ---- lock: m0 LW lock=1, then SW lock=0, m1 requesting throughout ----
        reset_pulse();
        m1_req = 1'b1; m1_addr = 32'h4; m1_is_load = 3'b011;
        m0_req = 1'b1; m0_addr = 32'h0; m0_is_load = 3'b011; m0_lock = 1'b1;
        #1;
        chk("lk c1 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        m0_is_load = 3'b000; m0_is_store = 2'b11; m0_wdata = 32'h000080FF; m0_lock = 1'b0;
        #1;
`ifdef DMEM_ARB_LOCK_EN
        chk("lk c2 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        m0_req = 1'b0;
        #1;
        chk("lk c3 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
`else
        chk("nolk c2 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
        @(posedge clk); #1;
        #1;
        chk("nolk c3 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
`endif
        @(posedge clk); #1;

        // ---- reset in the cycle after a grant drops the response ----
        reset_pulse();
        m0_req = 1'b1; m0_addr = 32'h0; m0_is_load = 3'b011;
        #1;
        chk("mid gnt", {31'h0, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("mid rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("post%0d rvalid", c), {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
            chk($sformatf("post%0d gnt", c),    {30'h0, m1_gnt, m0_gnt}, 32'h0);
            chk($sformatf("post%0d err", c),    {30'h0, m1_err, m0_err}, 32'h0);
            chk($sformatf("post%0d rdata", c),  m0_rdata | m1_rdata, 32'h0);
            chk($sformatf("post%0d mem", c),
                mem_addr | mem_wdata | {27'h0, mem_is_load, mem_is_store}, 32'h0);
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
